// File: rtl/read_master.sv
// read_master: replays a block of samples from DDR3 as a rate-paced stream, prefetching through a
// credit-limited FIFO. Define READ_MASTER_LOOP_EN to enable CSR 7 (continuous loop playback).
module read_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_read,
  input  logic              ddr_waitrequest,
  input  logic [DATA_W-1:0] ddr_readdata,
  input  logic              ddr_readdatavalid,
  input  logic [2:0]        addr,
  input  logic              read,
  input  logic              write,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [DATA_W-1:0] d_out,
  output logic              v_out,
  input  logic              ready_in
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | issuing reads into the prefetch FIFO
  // DRAIN | all reads issued, emptying responses and FIFO
  // DONE  | pass complete, done=1
  // FLUSH | soft reset, waiting out in-flight reads
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE, S_FLUSH} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_next;

  logic [ADDR_W-1:0] base_q;
  logic [15:0]       length_q, step_q, rate_q;
  logic              loop_en;

  logic [15:0]       idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  outstanding, fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [15:0]       rate_cnt;
  logic              req_held;

  logic              start_wr, srst_wr, start_ok, streaming, credit;
  logic              accept, rsp, push, emit, last_accept, drain_ok, done, busy;
  logic [CNT_W:0]    inflight;
  logic [15:0]       rd_mux;

  assign start_wr  = write && (addr == 3'd4);
  assign srst_wr   = write && (addr == 3'd6);
  assign start_ok  = start_wr && (state == S_IDLE || state == S_DONE);
  assign streaming = (state == S_FETCH) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign busy      = streaming || (state == S_FLUSH);

  // Requests in flight plus buffered samples may never exceed the FIFO size.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign credit   = inflight < (CNT_W+1)'(FIFO_DEPTH);

  // In FLUSH only a request already stalled by waitrequest is carried to completion.
  assign ddr_read = ((state == S_FETCH) && credit) || ((state == S_FLUSH) && req_held);
  assign ddr_addr = cur_addr;
  assign accept   = ddr_read && !ddr_waitrequest;

  // Responses with nothing outstanding belong to requests cut off by reset.
  assign rsp  = ddr_readdatavalid && (outstanding != '0);
  assign push = rsp && streaming;
  assign emit = streaming && (rate_cnt == 16'd0) && (fifo_cnt != '0) && ready_in;

  assign v_out = emit;
  assign d_out = emit ? mem[rd_ptr] : '0;

  assign last_accept = accept && (state == S_FETCH) &&
                       (({1'b0, idx} + 17'd1) >= {1'b0, length_q});
  assign drain_ok    = (outstanding == '0) && ((fifo_cnt - CNT_W'(emit)) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (srst_wr)       state_next = S_IDLE;
        else if (start_wr) state_next = (length_q != 16'd0) ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        if (srst_wr)                      state_next = S_FLUSH;
        else if (last_accept && !loop_en) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (srst_wr)       state_next = S_FLUSH;
        else if (drain_ok) state_next = S_DONE;
      end
      S_FLUSH: begin
        if (outstanding == '0 && !ddr_read) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      cur_addr    <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rate_cnt    <= '0;
      req_held    <= 1'b0;
    end else begin
      req_held <= ddr_read && ddr_waitrequest;

      if (start_ok) begin
        idx      <= '0;
        cur_addr <= base_q;
      end else if (accept && state == S_FETCH) begin
        if (last_accept) begin
          idx      <= '0;
          cur_addr <= base_q;
        end else begin
          idx      <= idx + 16'd1;
          cur_addr <= cur_addr + ADDR_W'(step_q);
        end
      end

      case ({accept, rsp})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase

      if (srst_wr || state == S_FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (emit) rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(emit);
      end

      // Pacing counter parks at 0 until a sample actually leaves.
      if (!streaming)                 rate_cnt <= '0;
      else if (rate_cnt == 16'd0) begin
        if (emit && rate_q != 16'd0)  rate_cnt <= 16'd1;
      end else if (rate_cnt >= rate_q) rate_cnt <= '0;
      else                            rate_cnt <= rate_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ddr_readdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || srst_wr) begin
      base_q   <= '0;
      length_q <= '0;
      step_q   <= 16'd1;
      rate_q   <= '0;
    end else if (write) begin
      case (addr)
        3'd0:    base_q   <= ADDR_W'(writedata);
        3'd1:    length_q <= writedata;
        3'd2:    step_q   <= writedata;
        3'd3:    rate_q   <= writedata;
        default: ;
      endcase
    end
  end

`ifdef READ_MASTER_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk) begin
    if (!rst_n || srst_wr)            loop_q <= 1'b0;
    else if (write && addr == 3'd7)   loop_q <= writedata[0];
  end

  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif

  always_comb begin
    rd_mux = 16'hDEAD;
    case (addr)
      3'd0: rd_mux = 16'(base_q);
      3'd1: rd_mux = length_q;
      3'd2: rd_mux = step_q;
      3'd3: rd_mux = rate_q;
      3'd5: rd_mux = {14'd0, busy, done};
`ifdef READ_MASTER_LOOP_EN
      3'd7: rd_mux = {15'd0, loop_q};
`endif
      default: rd_mux = 16'hDEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) readdata <= '0;
    else        readdata <= read ? rd_mux : 16'd0;
  end

endmodule

// File: tb/tb_read_master.sv
// Bench for read_master: CSR vector table, behavioural DDR slave with configurable latency and
// random stalls, and directed playback/pacing/flush/reset sequences.
module tb_read_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ddr_addr;
  logic        ddr_read;
  logic        ddr_waitrequest = 1'b0;
  logic [15:0] ddr_readdata = '0;
  logic        ddr_readdatavalid = 1'b0;
  logic [2:0]  addr;
  logic        read, write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] d_out;
  logic        v_out;
  logic        ready_in;

  read_master #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_waitrequest(ddr_waitrequest),
    .ddr_readdata(ddr_readdata), .ddr_readdatavalid(ddr_readdatavalid),
    .addr(addr), .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .d_out(d_out), .v_out(v_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // DDR slave model and output monitor
  typedef struct { int due; logic [15:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  logic [15:0] acc_a[$];
  int          acc_c[$];
  logic [15:0] got_d[$];
  int          got_c[$];
  logic [15:0] rd_hist[int];
  int          lat = 1;
  bit          wait_rand = 0;
  bit          occ_chk = 0;
  int          acc_n = 0, out_n = 0, rd_cycles = 0;
  bit          held = 0;
  logic [15:0] held_addr = '0;

  always begin
    rsp_t r;
    @(negedge clk);
    if (held) check("stall_hold", {15'd0, ddr_read, ddr_addr}, {15'd0, 1'b1, held_addr});
    if (ddr_read) rd_cycles++;
    if (ddr_read && !ddr_waitrequest) begin
      r.due  = cyc + lat;
      r.data = ddr_addr;
      rsp_q.push_back(r);
      acc_a.push_back(ddr_addr);
      acc_c.push_back(cyc);
      acc_n++;
    end
    held      = ddr_read && ddr_waitrequest;
    held_addr = ddr_addr;
    if (v_out) begin
      got_d.push_back(d_out);
      got_c.push_back(cyc);
      out_n++;
      check("vout_while_not_ready", {31'd0, ready_in}, 32'd1);
    end
    if (occ_chk) check("occupancy_le_8", {31'd0, (acc_n - out_n) <= 8}, 32'd1);
    rd_hist[cyc] = readdata;
    @(posedge clk); #1;
    ddr_readdatavalid = 1'b0;
    ddr_readdata      = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      ddr_readdatavalid = 1'b1;
      ddr_readdata      = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    ddr_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
    addr = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
    addr = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic clear_logs();
    got_d.delete(); got_c.delete(); acc_a.delete(); acc_c.delete();
    acc_n = 0; out_n = 0;
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int k = 0;
    while (got_d.size() < n && k < budget) begin tick(); k++; end
    check(nm, got_d.size(), n);
  endtask

  task automatic wait_idle(input string nm);
    logic [15:0] s = 16'hFFFF;
    int k = 0;
    while (s[1] && k < 300) begin csr_read(3'd5, s); k++; end
    check(nm, {31'd0, s[1]}, 32'd0);
  endtask

  task automatic config_run(input logic [15:0] b, input logic [15:0] len,
                            input logic [15:0] st, input logic [15:0] rt);
    csr_write(3'd0, b); csr_write(3'd1, len); csr_write(3'd2, st); csr_write(3'd3, rt);
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [15:0] exp;
  } csr_vec_t;

`ifdef READ_MASTER_LOOP_EN
  localparam logic [15:0] R7_SET = 16'h0001, R7_CLR = 16'h0000;
`else
  localparam logic [15:0] R7_SET = 16'hDEAD, R7_CLR = 16'hDEAD;
`endif

  initial begin
    csr_vec_t    vecs[14];
    logic [15:0] s;
    int          c0, t, rdc, on;

    vecs[0]  = '{0, 3'd0, 16'h0000, 3'd0, 16'h0000};
    vecs[1]  = '{0, 3'd0, 16'h0000, 3'd1, 16'h0000};
    vecs[2]  = '{0, 3'd0, 16'h0000, 3'd2, 16'h0001};
    vecs[3]  = '{0, 3'd0, 16'h0000, 3'd3, 16'h0000};
    vecs[4]  = '{0, 3'd0, 16'h0000, 3'd5, 16'h0000};
    vecs[5]  = '{0, 3'd0, 16'h0000, 3'd7, R7_CLR};
    vecs[6]  = '{1, 3'd0, 16'hABCD, 3'd0, 16'hABCD};
    vecs[7]  = '{1, 3'd1, 16'h0010, 3'd1, 16'h0010};
    vecs[8]  = '{1, 3'd2, 16'h0005, 3'd2, 16'h0005};
    vecs[9]  = '{1, 3'd3, 16'h0007, 3'd3, 16'h0007};
    vecs[10] = '{1, 3'd7, 16'h0001, 3'd7, R7_SET};
    vecs[11] = '{1, 3'd6, 16'h0000, 3'd2, 16'h0001};
    vecs[12] = '{0, 3'd0, 16'h0000, 3'd0, 16'h0000};
    vecs[13] = '{0, 3'd0, 16'h0000, 3'd7, R7_CLR};

    rst_n = 1'b0; addr = '0; read = 1'b0; write = 1'b0; writedata = '0; ready_in = 1'b1;
    tick(2);
    check("rst_ddr_read", {31'd0, ddr_read}, 32'd0);
    check("rst_ddr_addr", ddr_addr, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_d_out",    d_out, 32'd0);
    check("rst_v_out",    {31'd0, v_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) csr_write(vecs[i].wa, vecs[i].wd);
      csr_read(vecs[i].ra, s);
      check($sformatf("csr_vec%0d", i), s, vecs[i].exp);
    end
    tick();
    check("readdata_zero_no_read", readdata, 32'd0);

    // Basic playback, single-cycle DDR latency
    config_run(16'h0100, 16'd4, 16'd1, 16'd0);
    clear_logs(); lat = 1;
    csr_write(3'd4, 16'h0);
    c0 = cyc;
    addr = 3'd5; read = 1'b1;
    wait_out(4, 50, "t1_count");
    tick(3);
    read = 1'b0;
    for (int i = 0; i < 4 && i < got_d.size(); i++) check("t1_data", got_d[i], 32'h100 + i);
    if (acc_c.size() > 0) check("t1_first_read_cycle", acc_c[0], c0);
    if (got_c.size() >= 4) begin
      check("t1_first_vout_cycle", got_c[0], c0 + 2);
      for (int i = 1; i < 4; i++) check("t1_consecutive", got_c[i] - got_c[i-1], 1);
      t = got_c[3];
      check("t1_status_at_last", rd_hist[t+1], 32'h2);
      check("t1_status_after",   rd_hist[t+2], 32'h1);
    end

    // Address wrap with step 3
    config_run(16'hFFFE, 16'd3, 16'd3, 16'd0);
    clear_logs();
    csr_write(3'd4, 16'h0);
    wait_out(3, 50, "t2_count");
    wait_idle("t2_idle");
    check("t2_nreq", acc_a.size(), 3);
    for (int i = 0; i < 3 && i < acc_a.size(); i++)
      check("t2_addr", acc_a[i], (32'hFFFE + 3 * i) & 32'hFFFF);
    for (int i = 0; i < 3 && i < got_d.size(); i++)
      check("t2_data", got_d[i], (32'hFFFE + 3 * i) & 32'hFFFF);

    // Rate pacing
    config_run(16'h0200, 16'd5, 16'd1, 16'd3);
    clear_logs();
    csr_write(3'd4, 16'h0);
    wait_out(5, 100, "t3a_count");
    wait_idle("t3a_idle");
    for (int i = 1; i < got_c.size(); i++) check("t3a_spacing", got_c[i] - got_c[i-1], 4);

    // Backpressure mid-stream
    config_run(16'h0280, 16'd8, 16'd1, 16'd3);
    clear_logs();
    csr_write(3'd4, 16'h0);
    wait_out(2, 50, "t3b_first2");
    ready_in = 1'b0;
    tick(10);
    ready_in = 1'b1;
    wait_out(8, 100, "t3b_count");
    wait_idle("t3b_idle");
    for (int i = 0; i < 8 && i < got_d.size(); i++) check("t3b_order", got_d[i], 32'h280 + i);

    // Random stalls, latency 6
    config_run(16'h0300, 16'd32, 16'd1, 16'd0);
    clear_logs(); lat = 6; wait_rand = 1; occ_chk = 1;
    csr_write(3'd4, 16'h0);
    wait_out(32, 2000, "t4_count");
    wait_idle("t4_idle");
    wait_rand = 0; occ_chk = 0;
    tick(2);
    for (int i = 0; i < 32 && i < got_d.size(); i++) check("t4_order", got_d[i], 32'h300 + i);
    check("t4_nreq", acc_a.size(), 32);

    // Soft reset mid-run, then zero-length start
    config_run(16'h0400, 16'd16, 16'd1, 16'd0);
    clear_logs(); lat = 4;
    csr_write(3'd4, 16'h0);
    wait_out(3, 50, "t5_first3");
    csr_write(3'd6, 16'h0);
    rdc = rd_cycles; on = got_d.size();
    csr_read(3'd5, s);
    check("t5_flush_busy", s, 32'h2);
    wait_idle("t5_idle");
    tick(10);
    check("t5_no_new_read", rd_cycles, rdc);
    check("t5_no_vout", got_d.size(), on);
    csr_read(3'd0, s); check("t5_base_reset", s, 32'h0);
    csr_read(3'd1, s); check("t5_len_reset", s, 32'h0);
    csr_read(3'd2, s); check("t5_step_reset", s, 32'h1);
    csr_write(3'd4, 16'h0);
    csr_read(3'd5, s);
    check("t5_len0_done", s, 32'h1);
    check("t5_len0_no_read", rd_cycles, rdc);

    // Hard reset with responses in flight
    config_run(16'h0600, 16'd8, 16'd1, 16'd0);
    clear_logs(); lat = 6;
    csr_write(3'd4, 16'h0);
    tick(3);
    rst_n = 1'b0;
    tick();
    check("t6_ddr_read", {31'd0, ddr_read}, 32'd0);
    check("t6_ddr_addr", ddr_addr, 32'd0);
    check("t6_v_out", {31'd0, v_out}, 32'd0);
    rst_n = 1'b1;
    rdc = rd_cycles; on = got_d.size();
    tick(15);
    check("t6_no_vout", got_d.size(), on);
    check("t6_no_read", rd_cycles, rdc);
    csr_read(3'd1, s); check("t6_len_reset", s, 32'h0);

`ifdef READ_MASTER_LOOP_EN
    config_run(16'h0500, 16'd2, 16'd1, 16'd0);
    clear_logs(); lat = 1;
    csr_write(3'd7, 16'h1);
    csr_write(3'd4, 16'h0);
    wait_out(6, 100, "t7_count");
    for (int i = 0; i < 6 && i < got_d.size(); i++) check("t7_repeat", got_d[i], 32'h500 + (i % 2));
    csr_read(3'd5, s); check("t7_busy_not_done", s, 32'h2);
    csr_write(3'd7, 16'h0);
    wait_idle("t7_idle");
    csr_read(3'd5, s); check("t7_done_after_clear", s, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
